multi_input_gate: RTL and testbench

MULTI_INPUT_GATE -- requirements
Module: multi_input_gate

---
 rtl/multi_input_gate.sv | 66 ++++++
 tb/tb_multi_input_gate.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/multi_input_gate.sv
// Five-input configurable gate: fixed reductions, majority, or a 32-entry LUT
// indexed by {a,b,c,d,e}, with an optional output register.
module multi_input_gate #(
    parameter int unsigned MODE        = 7,
    parameter logic [31:0] TRUTH_TABLE = 32'hFF808080,
    parameter bit          REGISTERED  = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    input  logic e,
    output logic x
);

    logic [4:0] idx;
    logic [2:0] ones;
    logic       f;

    assign idx  = {a, b, c, d, e};
    assign ones = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d} + {2'b00, e};

    // Unlisted MODE values fall through to the lookup table.
    always_comb begin
        f = 1'b0;
        case (MODE)
            0:       f = &idx;
            1:       f = |idx;
            2:       f = ^idx;
            3:       f = ~(&idx);
            4:       f = ~(|idx);
            5:       f = ~(^idx);
            6:       f = (ones >= 3'd3);
            default: f = TRUTH_TABLE[idx];
        endcase
    end

    generate
        if (REGISTERED) begin : g_reg
            logic x_d;
            logic x_q;

            always_comb begin
                x_d = f;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    x_q <= 1'b0;
                end else begin
                    x_q <= x_d;
                end
            end

            assign x = x_q;
        end else begin : g_comb
            // Clock and reset are intentionally ignored in the combinational build.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst_n;
            assign x = f;
        end
    endgenerate

endmodule

// File: tb/tb_multi_input_gate.sv
// Randomized and directed checks of multi_input_gate across all modes,
// registered and combinational builds, against a popcount-based reference.
module tb_multi_input_gate;

    localparam int          N_REG  = 9;
    localparam logic [31:0] TT_DEF = 32'hFF808080;
    localparam logic [31:0] TT_ALT = 32'h5A3C96E1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0, e = 1'b0;
    wire  [N_REG-1:0] x_reg;
    wire  x_comb;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multi_input_gate u_lut (.clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .e(e), .x(x_reg[0]));
    multi_input_gate #(.MODE(1)) u_or (.clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .e(e), .x(x_reg[1]));
    multi_input_gate #(.MODE(2)) u_xor (.clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .e(e), .x(x_reg[2]));
    multi_input_gate #(.MODE(3)) u_nand (.clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .e(e), .x(x_reg[3]));
    multi_input_gate #(.MODE(0)) u_and (.clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .e(e), .x(x_reg[4]));
    multi_input_gate #(.MODE(4)) u_nor (.clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .e(e), .x(x_reg[5]));
    multi_input_gate #(.MODE(5)) u_xnor (.clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .e(e), .x(x_reg[6]));
    multi_input_gate #(.MODE(6)) u_maj (.clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .e(e), .x(x_reg[7]));
    multi_input_gate #(.MODE(9), .TRUTH_TABLE(TT_ALT)) u_bad (.clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .e(e), .x(x_reg[8]));
    multi_input_gate #(.REGISTERED(1'b0)) u_comb (.clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .e(e), .x(x_comb));

    function automatic int mode_of(input int k);
        case (k)
            0: return 7;
            1: return 1;
            2: return 2;
            3: return 3;
            4: return 0;
            5: return 4;
            6: return 5;
            7: return 6;
            default: return 9;
        endcase
    endfunction

    // Default table written as its listed ones: 7, 15, 23 and 24..31.
    function automatic logic lut_default(input int i);
        return (i == 7) || (i == 15) || (i == 23) || (i >= 24);
    endfunction

    function automatic logic ref_f(input int m, input logic [31:0] tt, input int i);
        int pc = 0;
        for (int k = 0; k < 5; k++) pc += (i >> k) & 1;
        case (m)
            0: return pc == 5;
            1: return pc > 0;
            2: return (pc % 2) == 1;
            3: return pc != 5;
            4: return pc == 0;
            5: return (pc % 2) == 0;
            6: return pc >= 3;
            default: return tt[i];
        endcase
    endfunction

    function automatic logic exp_reg(input int k, input int i);
        if (k == 0) return lut_default(i);
        if (k == 8) return ref_f(9, TT_ALT, i);
        return ref_f(mode_of(k), TT_DEF, i);
    endfunction

    task automatic check_bit(input string tag, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic drive(input int i);
        logic [4:0] v;
        v = i[4:0];
        {a, b, c, d, e} = v;
    endtask

    task automatic check_regs(input string tag, input int i);
        for (int k = 0; k < N_REG; k++)
            check_bit($sformatf("%s mode%0d idx%0d", tag, mode_of(k), i), x_reg[k], exp_reg(k, i));
    endtask

    task automatic check_zero(input string tag);
        for (int k = 0; k < N_REG; k++)
            check_bit($sformatf("%s mode%0d", tag, mode_of(k)), x_reg[k], 1'b0);
    endtask

    task automatic check_comb(input string tag, input int i);
        check_bit($sformatf("%s comb idx%0d", tag, i), x_comb, lut_default(i));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int i;
        int other;

        // Reset held: registered outputs 0 regardless of inputs, comb unaffected.
        drive(31);
        #2;
        check_zero("rst_idx31");
        check_comb("rst", 31);
        drive(24);
        #1;
        check_zero("rst_idx24");
        check_comb("rst", 24);
        @(posedge clk); #1;
        check_zero("rst_edge");

        drive(13);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_zero("released_pre_edge");
        @(posedge clk); #1;
        check_regs("first_edge", 13);

        // Full sweep, plus between-edge input changes that must not reach x.
        for (int s = 0; s < 32; s++) begin
            @(negedge clk);
            drive(s);
            #1;
            check_comb("sweep", s);
            @(posedge clk); #1;
            check_regs("sweep", s);
            other = s ^ 21;
            drive(other);
            #1;
            check_regs("hold", s);
            check_comb("hold", other);
        end

        for (int r = 0; r < 100; r++) begin
            @(negedge clk);
            i = int'($urandom_range(0, 31));
            drive(i);
            #1;
            check_comb("rand", i);
            @(posedge clk); #1;
            check_regs("rand", i);
        end

        // Asynchronous reset mid-cycle with idx=31 held.
        @(negedge clk);
        drive(31);
        @(posedge clk); #1;
        check_regs("pre_async", 31);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        check_comb("async_rst", 31);
        @(posedge clk); #1;
        check_zero("async_rst_edge");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_zero("async_release");
        @(posedge clk); #1;
        check_regs("after_release", 31);

        // A reset pulse between edges discards the old value; next edge loads new inputs.
        @(negedge clk);
        drive(24);
        #1;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
        check_zero("pulse_clear");
        @(posedge clk); #1;
        check_regs("pulse_reload", 24);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
